// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM dead-time stage.
package pwm_pkg;

    localparam int PWM_DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DT_HS = 3'd1,
        ST_HS_ON = 3'd2,
        ST_DT_LS = 3'd3,
        ST_LS_ON = 3'd4,
        ST_FAULT = 3'd5
    } pwm_dt_state_e;

endpackage

// File: rtl/pwm_in_filter.sv
// Input register for the PWM stream; with PWM_DT_GLITCH_FILTER_EN defined, a
// 2-sample agreement filter that rejects single-cycle glitches.
module pwm_in_filter
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm_in,
    output logic o_pwm_q
);

    logic r_pwm_q;

`ifdef PWM_DT_GLITCH_FILTER_EN
    logic r_pwm_s1;

    // A new level is accepted only when two consecutive samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_s1 <= 1'b0;
            r_pwm_q  <= 1'b0;
        end else begin
            r_pwm_s1 <= i_pwm_in;
            if (i_pwm_in == r_pwm_s1)
                r_pwm_q <= i_pwm_in;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pwm_q <= 1'b0;
        else
            r_pwm_q <= i_pwm_in;
    end
`endif

    assign o_pwm_q = r_pwm_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate drive with programmable dead time and fault latch.
// Optional input glitch filter: define PWM_DT_GLITCH_FILTER_EN.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = PWM_DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_pwm_in,
    input  logic [DT_W-1:0] i_dt_data_in,
    input  logic            i_dt_update,
    input  logic            i_fault_in,
    input  logic            i_fault_clr,
    output logic            o_hs_out,
    output logic            o_ls_out,
    output logic            o_fault_latched
);

    logic            w_pwm_q;
    pwm_dt_state_e   r_state;
    pwm_dt_state_e   w_state_nxt;
    logic [DT_W-1:0] r_dt_shadow;
    logic [DT_W-1:0] r_dt_active;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_nxt;
    logic            w_load_active;
    logic            w_enter_hs;
    logic            w_enter_ls;
    logic            w_dt_expired;

    pwm_in_filter u_in_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pwm_in (i_pwm_in),
        .o_pwm_q  (w_pwm_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dt_shadow <= '0;
        else if (i_dt_update)
            r_dt_shadow <= i_dt_data_in;
    end

    // Zero active value can only mean a bypassed phase; treat it as expired.
    assign w_dt_expired = (r_cnt == '0) || (r_dt_active == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load_active = 1'b0;
        w_enter_hs    = 1'b0;
        w_enter_ls    = 1'b0;

        if (i_fault_in) begin
            w_state_nxt = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            if (i_fault_clr)
                w_state_nxt = ST_IDLE;
        end else if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_enter_hs = w_pwm_q;
                    w_enter_ls = !w_pwm_q;
                end
                ST_HS_ON: w_enter_ls = !w_pwm_q;
                ST_LS_ON: w_enter_hs = w_pwm_q;
                ST_DT_HS, ST_DT_LS: begin
                    if (w_dt_expired)
                        w_state_nxt = w_pwm_q ? ST_HS_ON : ST_LS_ON;
                    else
                        w_cnt_nxt = r_cnt - DT_W'(1);
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            // Dead phase entry samples the shadow; zero bypasses straight to ON.
            if (w_enter_hs || w_enter_ls) begin
                if (r_dt_shadow == '0) begin
                    w_state_nxt = w_enter_hs ? ST_HS_ON : ST_LS_ON;
                end else begin
                    w_state_nxt   = w_enter_hs ? ST_DT_HS : ST_DT_LS;
                    w_cnt_nxt     = r_dt_shadow - DT_W'(1);
                    w_load_active = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dt_active <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_active)
                r_dt_active <= r_dt_shadow;
        end
    end

    assign o_hs_out        = (r_state == ST_HS_ON);
    assign o_ls_out        = (r_state == ST_LS_ON);
    assign o_fault_latched = (r_state == ST_FAULT);

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Complementary-output stage placed directly downstream of the shadow-register PWM core. It consumes the single-ended `pwm_out` and drives a high-side/low-side gate pair. Every transition between the two sides is separated by a programmable dead time, during which both outputs are low. Pulses shorter than the dead time are absorbed, and an external fault forces both outputs low until software clears it.

## Interface
- `DT_W`, 8, width of dead-time count (max dead time 2^DT_W−1 cycles)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  stage enable; low forces IDLE, both outputs low
- `pwm_in`  in  1  PWM from core (`pwm_out`); synchronous to `clk`
- `dt_data_in`  in  DT_W  new dead-time value from CPU
- `dt_update`  in  1  single-cycle strobe; captures `dt_data_in` into shadow
- `fault_in`  in  1  synchronous fault request, level
- `fault_clr`  in  1  single-cycle strobe; releases fault latch
- `hs_out`  out  1  high-side gate drive
- `ls_out`  out  1  low-side gate drive
- `fault_latched`  out  1  high while in FAULT state

## Operation
- Input path: `pwm_in` is registered once into `pwm_q`. All FSM decisions use `pwm_q`.
- Dead-time shadow: `dt_shadow_q` updates on `dt_update`. `dt_active_q` loads from the shadow on entry to every dead state, so a change never alters a dead phase in progress.
- FSM states: IDLE, DT_HS, HS_ON, DT_LS, LS_ON, FAULT.
- Outputs are decoded from the state register: `hs_out` = (state==HS_ON), `ls_out` = (state==LS_ON), `fault_latched` = (state==FAULT).
- **IDLE**, en=1:
  - `pwm_q`=1 → DT_HS.
  - `pwm_q`=0 → DT_LS.
  - A dead phase therefore always precedes the first drive after enable.
- **HS_ON**: `pwm_q`=0 → DT_LS.
- **LS_ON**: `pwm_q`=1 → DT_HS.
- **DT_HS / DT_LS** (D = shadow value at entry):
  - Counter loads D−1 and decrements; the state is held exactly D cycles.
  - On expiry: DT_HS → HS_ON if `pwm_q`=1, else → LS_ON. DT_LS → LS_ON if `pwm_q`=0, else → HS_ON.
  - A pulse shorter than D is thus suppressed and no side is re-driven.
- D=0: dead states are bypassed. HS_ON↔LS_ON switch directly, and IDLE goes straight to the ON state matching `pwm_q`.
- **FAULT**:
  - Entered from any state when `fault_in`=1.
  - Exits to IDLE only on `fault_clr`=1 with `fault_in`=0 in the same cycle.
- Priority, highest first: reset, `fault_in`, !en, normal FSM.
  - `fault_in` and `fault_clr` together → stay in FAULT.
  - en=0 while in FAULT → stay in FAULT.
- Invariant: `hs_out` and `ls_out` are never both 1 in any cycle, in any state or configuration.

## Timing
- Reset values:
  - state=IDLE; `pwm_q`=0; `dt_shadow_q`=0; `dt_active_q`=0; counter=0.
  - `hs_out`=0, `ls_out`=0, `fault_latched`=0.
- Edge latency:
  - A `pwm_in` change at edge E0 is seen in `pwm_q` at E1, and the state leaves ON at E2, so the driven side drops 2 cycles after the input edge.
  - The opposite side rises at E2+D.
- Enable: `en` falling → outputs low at the next edge. `en` rising → first dead state entered the following edge.
- Fault: `fault_in` high at edge E → outputs low and `fault_latched`=1 after E (1 cycle).
- Dead-time update: `dt_update` at edge E → the shadow holds the new value after E. The next dead-state entry strictly after E uses it.
- Reset asserted mid-operation: outputs low immediately (asynchronous), not waiting for a clock edge.

## Configuration
- `PWM_DT_GLITCH_FILTER_EN` defined:
  - Input uses a 2-stage agreement filter; `pwm_q` changes only after `pwm_in` holds the new level for 2 consecutive samples.
  - 1-cycle input glitches are rejected.
  - Edge latency becomes 3 cycles.
- Macro undefined: single register as above; latency 2 cycles.

## Structure
- Shared package `pwm_pkg`:
  - `pwm_dt_state_e` enum (the 6 states above).
  - `PWM_DT_W_DEFAULT` = 8.
- One sub-module, `pwm_in_filter`: holds the input register plus the optional glitch filter (macro-controlled). Output is `pwm_q`.
- Top level holds the shadow/active registers, dead counter, FSM and output decode.

## Test plan
- Reset release, D=4, `pwm_in` held 0, en=1 → IDLE→DT_LS; `ls_out` rises 4 cycles after DT_LS entry; `hs_out` stays 0.
- D=3, `pwm_in` 0→1 at E0 from LS_ON → `ls_out` drops at E2, `hs_out` rises at E5; no cycle with both high.
- D=5, `pwm_in` high pulse of 2 cycles from LS_ON → `hs_out` never asserts; `ls_out` returns after 5 dead cycles.
- D=0, `pwm_in` toggling every 4 cycles → direct HS/LS alternation, 4-cycle segments, delayed 2 cycles from input.
- `dt_update`=9 mid-DT_HS with D=2 → current dead phase lasts 2 cycles; next phase lasts 9.
- `fault_in` pulsed in HS_ON → both outputs low next cycle, `fault_latched`=1. `fault_clr` with `fault_in`=1 → stays in FAULT. `fault_clr` with `fault_in`=0 → IDLE, then a dead phase before any drive.
